uart_rx_byte: RTL

//  UART 8N1 serial receiver: oversamples the asynchronous RXD pin with the system clock.

---
 rtl/uart_rx_byte.sv | 105 ++++++++++
 1 files changed

// File: rtl/uart_rx_byte.sv
// UART 8N1 receiver: oversampled RXD, one byte per frame with a one-cycle done strobe.
// Latency ~9.5 bit periods + 4 clk from start edge; no backpressure, consumer must take uart_data on uart_done.
module uart_rx_byte #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic       uart_done,
    output logic [7:0] uart_data,
    output logic       frame_err,
    output logic       rx_busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             sync1, sync2, sync3;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync3     <= 1'b1;
            uart_done <= 1'b0;
            uart_data <= 8'h00;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            sync1     <= uart_rxd;
            sync2     <= sync1;
            sync3     <= sync2;
            uart_done <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= (state != IDLE);

            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                    if (sync3 && !sync2)
                        state <= START;
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        // a line already high again at mid start bit was only a glitch
                        state <= sync2 ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        shift_reg <= {sync2, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    // leave at mid stop bit so a back-to-back start edge is not missed
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (sync2) begin
                            uart_data <= shift_reg;
                            uart_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                BREAK: begin
                    cnt <= '0;
                    if (sync2)
                        state <= IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
